// File: rtl/dev_timer_if.sv
// ---------------------------------------------------------------------------
// dev_timer_if
//   CPU device-bus bundle between the CPU (master) and a memory-mapped
//   device such as dev_timer (slave).
//
//   praddr  CPU -> dev  32  byte address
//   wdin    CPU -> dev  32  write data
//   wecpu   CPU -> dev   1  write strobe, already qualified as device space
//   hit     dev -> CPU   1  address falls inside the device window
//   rdd     dev -> CPU  32  combinational read data, 0 when !hit
//   intreq  dev -> CPU   1  interrupt request
// ---------------------------------------------------------------------------
interface dev_timer_if;
    logic [31:0] praddr;
    logic [31:0] wdin;
    logic        wecpu;
    logic        hit;
    logic [31:0] rdd;
    logic        intreq;

    modport master (
        output praddr, wdin, wecpu,
        input  hit, rdd, intreq
    );

    modport slave (
        input  praddr, wdin, wecpu,
        output hit, rdd, intreq
    );
endinterface

// File: rtl/dev_timer.sv
// ---------------------------------------------------------------------------
// dev_timer
//   Memory-mapped programmable down-counter on the CPU device bus. Decodes
//   a 16-byte window at BASE, services register writes, returns read data
//   combinationally and raises an interrupt either once (one-shot) or as a
//   one-cycle pulse every PRESET+3 cycles (auto-reload).
//
//   Register map (offset = praddr[3:2], praddr[1:0] ignored):
//     0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, else one-shot), [3] IM
//     1 PRESET 32-bit read/write
//     2 COUNT  32-bit read-only
//     3 -      reads 0, writes ignored
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high
//     bus    dev_timer_if.slave (praddr, wdin, wecpu, hit, rdd, intreq)
// ---------------------------------------------------------------------------
module dev_timer #(
    parameter logic [31:0] BASE = 32'h0000_7f00
) (
    input  logic          clk,
    input  logic          reset,
    dev_timer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PRESET = 2'd1,
        REG_COUNT  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_e;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_e      state_q;
    logic        en_q;
    logic [1:0]  mode_q;
    logic        im_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_q;

    logic        hit;
    reg_e        reg_sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] rd_data;

    // Data bits above CTRL[3] and the byte-lane bits of the address carry
    // no meaning for this device.
    logic unused_bits;
    assign unused_bits = ^{bus.wdin[31:4], bus.praddr[1:0]};

    // -----------------------------------------------------------------------
    // Address decode and read mux
    // -----------------------------------------------------------------------
    assign hit       = (bus.praddr[31:4] == BASE[31:4]);
    assign reg_sel   = reg_e'(bus.praddr[3:2]);
    assign wr_ctrl   = bus.wecpu && hit && (reg_sel == REG_CTRL);
    assign wr_preset = bus.wecpu && hit && (reg_sel == REG_PRESET);

    // NOTE: every output of an always_comb block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        rd_data = '0;
        if (hit) begin
            unique case (reg_sel)
                REG_CTRL:   rd_data = {28'b0, im_q, mode_q, en_q};
                REG_PRESET: rd_data = preset_q;
                REG_COUNT:  rd_data = count_q;
                REG_RSVD:   rd_data = '0;
            endcase
        end
    end

    assign bus.hit    = hit;
    assign bus.rdd    = rd_data;
    // Both terms are flops, so intreq is glitch-free towards the CPU.
    assign bus.intreq = irq_q & im_q;

    // -----------------------------------------------------------------------
    // Timer FSM and register file
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only. The software
    // write section sits after the FSM case on purpose: when both touch the
    // same register on one edge, the later non-blocking assignment is the one
    // that lands, which gives the bus write priority over the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_q) begin
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end

                CNT: begin
                    if (!en_q) begin
                        state_q <= IDLE;
                    end else if (count_q != '0) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        state_q <= INT;
                        irq_q   <= 1'b1;
                    end
                end

                INT: begin
                    if (mode_q == MODE_RELOAD) begin
                        // Auto-reload: one-cycle pulse, keep running.
                        state_q <= LOAD;
                        irq_q   <= 1'b0;
                    end else begin
                        // One-shot: flag stays up until software touches
                        // CTRL or PRESET.
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                    end
                end
            endcase

            if (wr_ctrl) begin
                en_q   <= bus.wdin[0];
                mode_q <= bus.wdin[2:1];
                im_q   <= bus.wdin[3];
            end

            if (wr_preset) begin
                preset_q <= bus.wdin;
            end

            if (wr_ctrl || wr_preset) begin
                irq_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dev_timer.sv
// ---------------------------------------------------------------------------
// tb_dev_timer
//   Self-checking bench for dev_timer. Inputs change and outputs are sampled
//   just after the rising edge; "after Ek" means the value visible between
//   edge k and edge k+1, with E0 the edge that writes CTRL.EN=1.
// ---------------------------------------------------------------------------
module tb_dev_timer;

    localparam logic [31:0] BASE     = 32'h0000_7f00;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hc;
    localparam logic [31:0] A_MISS   = 32'h0000_7f40;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dev_timer_if bus ();

    dev_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.praddr = addr;
        bus.wdin   = data;
        bus.wecpu  = 1'b1;
        @(posedge clk);
        #1;
        bus.wecpu  = 1'b0;
        bus.wdin   = '0;
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] val);
        bus.praddr = addr;
        #1;
        val = bus.rdd;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] addrs [4];
        logic [31:0] obs;
        exp_t        e;
        addrs = '{A_CTRL, A_PRESET, A_COUNT, A_MISS};

        reset      = 1'b1;
        bus.praddr = '0;
        bus.wdin   = '0;
        bus.wecpu  = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("reset_hit_%0d", i), (i < 3) ? 32'd1 : 32'd0);
            push_exp($sformatf("reset_rdd_%0d", i), 32'd0);
        end
        push_exp("reset_intreq", 32'd0);

        for (int i = 0; i < 4; i++) begin
            peek(addrs[i], obs);
            e = sb_q.pop_front();
            total++;
            if ({31'b0, bus.hit} !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.hit}, e.val);
            end
            e = sb_q.pop_front();
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        e = sb_q.pop_front();
        total++;
        if ({31'b0, bus.intreq} !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
        end

        // A write outside the window must not land in PRESET.
        bus_write(A_MISS + 32'h4, 32'h0000_0077);
        push_exp("miss_write_preset", 32'd0);
        peek(A_PRESET, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_oneshot();
        logic [31:0] cnt_exp [7];
        logic [31:0] obs;
        exp_t        e;
        cnt_exp = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

        bus_write(A_PRESET, 32'd3);
        bus_write(A_CTRL, 32'h9);          // E0
        for (int k = 0; k < 7; k++) begin
            push_exp($sformatf("os_count_E%0d", k), cnt_exp[k]);
            push_exp($sformatf("os_intreq_E%0d", k), (k == 6) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick(1);
            peek(A_COUNT, obs);
            e = sb_q.pop_front();
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
            e = sb_q.pop_front();
            total++;
            if ({31'b0, bus.intreq} !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
            end
        end

        tick(1);                           // after E7: EN dropped, flag held
        push_exp("os_ctrl_E7", 32'h8);
        peek(A_CTRL, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        tick(3);
        push_exp("os_intreq_held", 32'd1);
        e = sb_q.pop_front();
        total++;
        if ({31'b0, bus.intreq} !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
        end

        bus_write(A_CTRL, 32'h8);
        push_exp("os_intreq_cleared", 32'd0);
        e = sb_q.pop_front();
        total++;
        if ({31'b0, bus.intreq} !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_auto_reload();
        logic [31:0] obs;
        exp_t        e;

        bus_write(A_PRESET, 32'd2);
        bus_write(A_CTRL, 32'hB);          // E0, period = 2 + 3
        for (int k = 0; k <= 20; k++) begin
            push_exp($sformatf("ar_intreq_E%0d", k),
                     (k >= 5 && (k % 5) == 0) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick(1);
            e = sb_q.pop_front();
            total++;
            if ({31'b0, bus.intreq} !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
            end
        end

        push_exp("ar_ctrl_still_en", 32'hB);
        peek(A_CTRL, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        bus_write(A_CTRL, 32'h0);
        tick(4);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stop_restart();
        logic [31:0] obs;
        exp_t        e;

        bus_write(A_PRESET, 32'd5);
        bus_write(A_CTRL, 32'h9);          // E0
        tick(4);                           // after E4
        push_exp("sr_count_E4", 32'd3);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        // Clearing EN on E5: the last decrement still happens (3 -> 2), then
        // the FSM parks in IDLE and COUNT holds.
        bus_write(A_CTRL, 32'h8);
        tick(4);                           // after E9
        push_exp("sr_count_held", 32'd2);
        push_exp("sr_intreq_none", 32'd0);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end
        e = sb_q.pop_front();
        total++;
        if ({31'b0, bus.intreq} !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
        end

        bus_write(A_CTRL, 32'h9);          // F0
        tick(2);                           // after F2
        push_exp("sr_reload", 32'd5);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        tick(6);                           // after F8 = F0 + 5 + 3
        push_exp("sr_intreq_F8", 32'd1);
        e = sb_q.pop_front();
        total++;
        if ({31'b0, bus.intreq} !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
        end
        tick(1);
        bus_write(A_CTRL, 32'h8);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_ignored_writes();
        logic [31:0] addrs [4];
        logic [31:0] want  [4];
        logic [31:0] obs;
        exp_t        e;
        addrs = '{A_COUNT, A_RSVD, A_PRESET, A_CTRL};
        want  = '{32'd0, 32'd0, 32'd5, 32'h8};

        bus_write(A_COUNT, 32'h0000_1234);
        bus_write(A_RSVD, 32'hffff_ffff);
        bus_write(A_CTRL, 32'hffff_fff8);  // only IM survives
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("ign_rd_%0d", i), want[i]);
        end
        for (int i = 0; i < 4; i++) begin
            peek(addrs[i], obs);
            e = sb_q.pop_front();
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_preset_live();
        logic [31:0] obs;
        exp_t        e;

        bus_write(A_PRESET, 32'd4);
        bus_write(A_CTRL, 32'hB);          // E0
        tick(2);                           // after E2: COUNT=4
        bus_write(A_PRESET, 32'd9);        // E3: current run keeps going
        push_exp("pl_count_E3", 32'd3);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        tick(4);                           // after E7 = E0 + 4 + 3
        push_exp("pl_intreq_E7", 32'd1);
        e = sb_q.pop_front();
        total++;
        if ({31'b0, bus.intreq} !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
        end

        tick(2);                           // after E9: reloaded from new PRESET
        push_exp("pl_count_E9", 32'd9);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        bus_write(A_CTRL, 32'h0);
        tick(3);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_full_range();
        logic [31:0] obs;
        exp_t        e;

        bus_write(A_PRESET, 32'hffff_ffff);
        bus_write(A_CTRL, 32'h1);          // E0
        push_exp("fr_count_E2", 32'hffff_ffff);
        push_exp("fr_count_E3", 32'hffff_fffe);
        for (int k = 2; k <= 3; k++) begin
            tick((k == 2) ? 2 : 1);
            peek(A_COUNT, obs);
            e = sb_q.pop_front();
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        bus_write(A_CTRL, 32'h0);
        tick(3);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_preset_zero_and_reset();
        logic [31:0] obs;
        exp_t        e;

        bus_write(A_PRESET, 32'd0);
        bus_write(A_CTRL, 32'h9);          // E0
        for (int k = 0; k <= 4; k++) begin
            push_exp($sformatf("pz_intreq_E%0d", k), (k >= 3) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick(1);
            e = sb_q.pop_front();
            total++;
            if ({31'b0, bus.intreq} !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
            end
        end

        // Reset between edges while the flag is held.
        #2 reset = 1'b1;
        #1;
        push_exp("ar_intreq_async", 32'd0);
        e = sb_q.pop_front();
        total++;
        if ({31'b0, bus.intreq} !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, {31'b0, bus.intreq}, e.val);
        end
        #1 reset = 1'b0;
        tick(1);

        // Reset between edges in the middle of a count.
        bus_write(A_PRESET, 32'd6);
        bus_write(A_CTRL, 32'h9);          // E0
        tick(4);                           // after E4
        push_exp("mr_count_before", 32'd4);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        #1 reset = 1'b1;
        push_exp("mr_count_async", 32'd0);
        push_exp("mr_preset_async", 32'd0);
        push_exp("mr_ctrl_async", 32'd0);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end
        peek(A_PRESET, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end
        peek(A_CTRL, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end

        tick(1);
        reset = 1'b0;
        tick(3);
        push_exp("mr_count_idle", 32'd0);
        peek(A_COUNT, obs);
        e = sb_q.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_stop_restart();
        test_ignored_writes();
        test_preset_live();
        test_full_range();
        test_preset_zero_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/dev_timer.md
Name: dev_timer

Overview:
Memory-mapped programmable timer on the CPU device bus; the responder side of the CPU's praddr/wdin/wecpu/rdd/intreq device interface.
Decodes its own 16-byte window, services register writes, and returns read data combinationally on rdd. Counts down from a preset and raises intreq to the CPU either once (one-shot) or periodically (auto-reload).
The system bridge ORs `hit` into its device-select and read-data mux.

Parameters:
BASE, 32'h0000_7f00, byte base address of the 16-byte register window (bits [3:0] must be zero)

Ports:
clk     input   1   system clock, all state updates on rising edge
reset   input   1   asynchronous, active-high; clears all state
praddr  input   32  byte address from CPU
wdin    input   32  write data from CPU
wecpu   input   1   device write strobe from CPU (already qualified as device space)
hit     output  1   praddr[31:4]==BASE[31:4], combinational
rdd     output  32  read data, combinational; 0 when !hit
intreq  output  1   interrupt request = irq_flag & CTRL.IM, registered source

Behaviour:
Register map, offset = praddr[3:2]; praddr[1:0] ignored:
- 0 CTRL: [0] EN, [2:1] MODE (00 one-shot; 01 auto-reload; 10/11 behave as 00), [3] IM. [31:4] read 0, writes ignored.
- 1 PRESET: 32-bit, read/write.
- 2 COUNT: 32-bit, read-only; writes ignored.
- 3: reads 0, writes ignored.

Write rule:
- A register is written at the rising edge when wecpu & hit.
- Any write to CTRL or PRESET clears irq_flag on that edge. A software write wins over the FSM's update of the same register on the same edge.

Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. rdd follows the decode (0 unless a hit reads nonzero data); intreq=0.

FSM (IDLE, LOAD, CNT, INT), evaluated on each edge:
- IDLE: EN=1 -> LOAD; otherwise stay. COUNT holds.
- LOAD: COUNT<=PRESET -> CNT.
- CNT:
  - EN=0 -> IDLE, COUNT holds its value.
  - Else COUNT!=0 -> COUNT<=COUNT-1, stay in CNT.
  - Else (COUNT==0) -> INT, irq_flag<=1.
- INT:
  - MODE=01 -> LOAD, irq_flag<=0 (one-cycle pulse), EN kept.
  - Otherwise EN<=0, irq_flag held (level until software write), -> IDLE.

Timing:
- One-shot: the CTRL write that sets EN occurs at edge E0; irq_flag rises at E0+N+3, where N=PRESET.
- Auto-reload: period is N+3 cycles; pulse width is 1 cycle.

Boundary conditions:
- PRESET=0: LOAD -> CNT -> INT, so irq at E0+3.
- PRESET written during CNT: takes effect only at the next LOAD.
- COUNT never wraps; decrement happens only when COUNT!=0.
- PRESET=32'hFFFF_FFFF: counts the full range with no overflow.
- EN cleared in INT by software on the same edge: the software value stands, and the FSM proceeds as in the INT rule.
- IM=0: irq_flag still sets, but intreq=0. Setting IM later exposes a held one-shot flag.
- Asynchronous reset mid-count: immediate return to reset values.
- Read of CTRL returns {28'b0, IM, MODE, EN}.

Test Plan:
1. Reset, then read BASE+0/4/8 (hit=1) -> rdd=0,0,0. Read 32'h0000_7f40 -> hit=0, rdd=0. intreq=0.
2. Write PRESET=3, then CTRL=4'b1001 at edge E0. COUNT reads 3,2,1,0 at E2..E5. intreq=1 after E6. CTRL reads 4'b1000 after E7. intreq stays high until a write CTRL=4'b1000 clears it.
3. PRESET=2, CTRL=4'b1011 (auto-reload) -> intreq 1-cycle pulses every 5 cycles. EN stays 1 across at least 3 periods.
4. One-shot with PRESET=5; clear EN when COUNT=2 -> COUNT holds 2, state IDLE, no intreq. Re-set EN -> reload from 5.
5. Write COUNT=32'h1234 and offset 3 -> ignored, reads unchanged. Write PRESET=9 during CNT -> current run unaffected; next auto-reload loads 9.
6. Assert reset at COUNT=4 with intreq pending -> all registers 0 and intreq=0 immediately (asynchronous). PRESET=0 one-shot -> intreq at E0+3.
